// File: rtl/n_set_cache_miss_sequencer_pkg.sv
// Purpose: shared FSM encoding, memory direction codes and width helper for the miss sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package n_set_cache_miss_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COMPARE  = 3'd1,
        ST_VICTIM   = 3'd2,
        ST_WB_REQ   = 3'd3,
        ST_FILL_REQ = 3'd4,
        ST_UPDATE   = 3'd5,
        ST_RESPOND  = 3'd6
    } seq_state_t;

    localparam logic MEM_RW_WRITEBACK = 1'b1;
    localparam logic MEM_RW_FILL      = 1'b0;

    // Ceiling log2; clog2(1) = 0 so a single-set or direct-mapped cache yields a zero-width field.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/n_set_tag_match.sv
// Purpose: combinational tag compare across the ways of one set; reports hit way and first free way.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//  way_valid/way_tag: per-way state of the addressed set; tag: lookup tag
//  hit/hit_way: lowest valid way whose tag matches; invalid_any/invalid_way: lowest invalid way
module n_set_tag_match
    import n_set_cache_miss_sequencer_pkg::*;
#(
    parameter int WAYS   = 4,
    parameter int BW_TAG = 8,
    parameter int BW_WAY = 2
) (
    input  logic [WAYS-1:0]             way_valid,
    input  logic [WAYS-1:0][BW_TAG-1:0] way_tag,
    input  logic [BW_TAG-1:0]           tag,
    output logic                        hit,
    output logic [BW_WAY-1:0]           hit_way,
    output logic                        invalid_any,
    output logic [BW_WAY-1:0]           invalid_way
);

    // Scan from the highest way down so the lowest matching / free way is the last one written.
    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        invalid_any = 1'b0;
        invalid_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_valid[w] && (way_tag[w] == tag)) begin
                hit     = 1'b1;
                hit_way = BW_WAY'(w);
            end
            if (!way_valid[w]) begin
                invalid_any = 1'b1;
                invalid_way = BW_WAY'(w);
            end
        end
    end

endmodule

// File: rtl/n_set_cache_miss_sequencer.sv
// Purpose: tag/valid/dirty store plus request sequencer: lookup, policy notify, write-back, fill, respond.
// Latency: hit responds 2 cycles after accept; miss adds victim choice, policy wait and memory handshakes.
// Backpressure: req_ready_o high only while idle (one request in flight); mem_req_o held until mem_ack_i.
//  req_*: block request in; resp_*: one-cycle location pulse out; policy_*: replacement controller link;
//  mem_*: next-level memory handshake. Cache location layout is {way, set}.
module n_set_cache_miss_sequencer
    import n_set_cache_miss_sequencer_pkg::*;
#(
    parameter  int CACHE_BLOCK_CAPACITY = 128,
    parameter  int CACHE_SET_SIZE       = 4,
    parameter  int BW_ADDR              = 26,
    localparam int BW_CACHE_CAPACITY    = clog2(CACHE_BLOCK_CAPACITY),
    localparam int BW_GRP               = clog2(CACHE_SET_SIZE),
    localparam int BW_SET               = BW_CACHE_CAPACITY - BW_GRP,
    localparam int BW_TAG               = BW_ADDR - BW_SET
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         req_valid_i,
    input  logic                         req_write_i,
    input  logic [BW_ADDR-1:0]           req_addr_i,
    output logic                         req_ready_o,
    output logic                         resp_valid_o,
    output logic                         resp_hit_o,
    output logic [BW_CACHE_CAPACITY-1:0] resp_cache_addr_o,
    output logic                         policy_hit_o,
    output logic                         policy_miss_o,
    output logic [BW_CACHE_CAPACITY-1:0] policy_addr_o,
    input  logic                         policy_done_i,
    input  logic [BW_CACHE_CAPACITY-1:0] policy_addr_i,
    output logic                         mem_req_o,
    output logic                         mem_rw_o,
    output logic [BW_ADDR-1:0]           mem_addr_o,
    output logic [BW_CACHE_CAPACITY-1:0] mem_cache_addr_o,
    input  logic                         mem_ack_i
);

    // Non-zero widths for way/set carriers; the unused bit stays 0 when the field is absent.
    localparam int BW_GRP_I = (BW_GRP > 0) ? BW_GRP : 1;
    localparam int BW_SET_I = (BW_SET > 0) ? BW_SET : 1;

    function automatic logic [BW_CACHE_CAPACITY-1:0] loc(input logic [BW_GRP_I-1:0] way,
                                                         input logic [BW_SET_I-1:0] set);
        logic [BW_CACHE_CAPACITY-1:0] way_part;
        logic [BW_CACHE_CAPACITY-1:0] set_part;
        way_part = BW_CACHE_CAPACITY'(way) << BW_SET;
        set_part = (BW_SET > 0) ? BW_CACHE_CAPACITY'(set) : '0;
        return way_part | set_part;
    endfunction

    function automatic logic [BW_ADDR-1:0] block_addr(input logic [BW_TAG-1:0]   tag,
                                                      input logic [BW_SET_I-1:0] set);
        logic [BW_ADDR-1:0] tag_part;
        logic [BW_ADDR-1:0] set_part;
        tag_part = BW_ADDR'(tag) << BW_SET;
        set_part = (BW_SET > 0) ? BW_ADDR'(set) : '0;
        return tag_part | set_part;
    endfunction

    seq_state_t                   state_q;
    logic                         req_write_q;
    logic [BW_ADDR-1:0]           req_addr_q;
    logic [BW_CACHE_CAPACITY-1:0] victim_q;

    logic [CACHE_BLOCK_CAPACITY-1:0] valid_q;
    logic [CACHE_BLOCK_CAPACITY-1:0] dirty_q;
    logic [BW_TAG-1:0]               tag_mem [CACHE_BLOCK_CAPACITY];

    logic [BW_SET_I-1:0] req_set;
    logic [BW_TAG-1:0]   req_tag;

    assign req_set = (BW_SET > 0) ? req_addr_q[BW_SET_I-1:0] : '0;
    assign req_tag = req_addr_q[BW_ADDR-1:BW_SET];

    logic [CACHE_SET_SIZE-1:0]             way_valid;
    logic [CACHE_SET_SIZE-1:0][BW_TAG-1:0] way_tag;

    always_comb begin
        for (int w = 0; w < CACHE_SET_SIZE; w++) begin
            way_valid[w] = valid_q[loc(BW_GRP_I'(w), req_set)];
            way_tag[w]   = tag_mem[loc(BW_GRP_I'(w), req_set)];
        end
    end

    logic                hit;
    logic [BW_GRP_I-1:0] hit_way;
    logic                invalid_any;
    logic [BW_GRP_I-1:0] invalid_way;

    n_set_tag_match #(
        .WAYS   (CACHE_SET_SIZE),
        .BW_TAG (BW_TAG),
        .BW_WAY (BW_GRP_I)
    ) u_tag_match (
        .way_valid   (way_valid),
        .way_tag     (way_tag),
        .tag         (req_tag),
        .hit         (hit),
        .hit_way     (hit_way),
        .invalid_any (invalid_any),
        .invalid_way (invalid_way)
    );

    logic [BW_CACHE_CAPACITY-1:0] hit_loc;
    logic [BW_CACHE_CAPACITY-1:0] victim_sel;

    assign hit_loc = loc(hit_way, req_set);
    // A free way always beats the policy's choice; policy_addr_i is only used once the set is full.
    assign victim_sel = invalid_any ? loc(invalid_way, req_set) : policy_addr_i;

    // Policy strobes are decoded straight from COMPARE so the controller sees them in the lookup cycle.
    always_comb begin
        policy_hit_o  = 1'b0;
        policy_miss_o = 1'b0;
        policy_addr_o = '0;
        if (state_q == ST_COMPARE) begin
            policy_hit_o  = hit;
            policy_miss_o = !hit;
            policy_addr_o = hit ? hit_loc : loc('0, req_set);
        end
    end

    // Tags carry no reset; a reset landing in UPDATE must not commit the new tag.
    always_ff @(posedge clock_i) begin
        if (!reset_i && (state_q == ST_UPDATE)) begin
            tag_mem[victim_q] <= req_tag;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q           <= ST_IDLE;
            req_write_q       <= 1'b0;
            req_addr_q        <= '0;
            victim_q          <= '0;
            valid_q           <= '0;
            dirty_q           <= '0;
            req_ready_o       <= 1'b1;
            resp_valid_o      <= 1'b0;
            resp_hit_o        <= 1'b0;
            resp_cache_addr_o <= '0;
            mem_req_o         <= 1'b0;
            mem_rw_o          <= MEM_RW_FILL;
            mem_addr_o        <= '0;
            mem_cache_addr_o  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        req_write_q <= req_write_i;
                        req_addr_q  <= req_addr_i;
                        req_ready_o <= 1'b0;
                        state_q     <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (hit) begin
                        if (req_write_q) begin
                            dirty_q[hit_loc] <= 1'b1;
                        end
                        resp_valid_o      <= 1'b1;
                        resp_hit_o        <= 1'b1;
                        resp_cache_addr_o <= hit_loc;
                        state_q           <= ST_RESPOND;
                    end else begin
                        state_q <= ST_VICTIM;
                    end
                end
                ST_VICTIM: begin
                    if (invalid_any || policy_done_i) begin
                        victim_q         <= victim_sel;
                        mem_cache_addr_o <= victim_sel;
                        mem_req_o        <= 1'b1;
                        if (valid_q[victim_sel] && dirty_q[victim_sel]) begin
                            mem_rw_o   <= MEM_RW_WRITEBACK;
                            mem_addr_o <= block_addr(tag_mem[victim_sel], req_set);
                            state_q    <= ST_WB_REQ;
                        end else begin
                            mem_rw_o   <= MEM_RW_FILL;
                            mem_addr_o <= req_addr_q;
                            state_q    <= ST_FILL_REQ;
                        end
                    end
                end
                ST_WB_REQ: begin
                    // Drop the request for one cycle; FILL_REQ re-raises it with the fill address.
                    if (mem_ack_i) begin
                        mem_req_o  <= 1'b0;
                        mem_rw_o   <= MEM_RW_FILL;
                        mem_addr_o <= req_addr_q;
                        state_q    <= ST_FILL_REQ;
                    end
                end
                ST_FILL_REQ: begin
                    if (mem_req_o && mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= ST_UPDATE;
                    end else if (!mem_req_o) begin
                        mem_req_o <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    valid_q[victim_q] <= 1'b1;
                    dirty_q[victim_q] <= req_write_q;
                    resp_valid_o      <= 1'b1;
                    resp_hit_o        <= 1'b0;
                    resp_cache_addr_o <= victim_q;
                    state_q           <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    resp_valid_o <= 1'b0;
                    resp_hit_o   <= 1'b0;
                    req_ready_o  <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n_set_cache_miss_sequencer.sv
// Purpose: self-checking bench for the miss sequencer (8 blocks, 2 ways, 4 sets, 8-bit addresses).
// Latency: n/a.
// Backpressure: bench plays the policy controller and next-level memory with programmable waits.
module tb_n_set_cache_miss_sequencer;

    localparam int CAP  = 8;
    localparam int WAYS = 2;
    localparam int SETS = 4;
    localparam int AW   = 8;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_write_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic          req_ready_o;
    logic          resp_valid_o;
    logic          resp_hit_o;
    logic [2:0]    resp_cache_addr_o;
    logic          policy_hit_o;
    logic          policy_miss_o;
    logic [2:0]    policy_addr_o;
    logic          policy_done_i = 1'b0;
    logic [2:0]    policy_addr_i = '0;
    logic          mem_req_o;
    logic          mem_rw_o;
    logic [AW-1:0] mem_addr_o;
    logic [2:0]    mem_cache_addr_o;
    logic          mem_ack_i = 1'b0;

    always #5 clock_i = ~clock_i;

    n_set_cache_miss_sequencer #(
        .CACHE_BLOCK_CAPACITY (CAP),
        .CACHE_SET_SIZE       (WAYS),
        .BW_ADDR              (AW)
    ) dut (
        .clock_i           (clock_i),
        .reset_i           (reset_i),
        .req_valid_i       (req_valid_i),
        .req_write_i       (req_write_i),
        .req_addr_i        (req_addr_i),
        .req_ready_o       (req_ready_o),
        .resp_valid_o      (resp_valid_o),
        .resp_hit_o        (resp_hit_o),
        .resp_cache_addr_o (resp_cache_addr_o),
        .policy_hit_o      (policy_hit_o),
        .policy_miss_o     (policy_miss_o),
        .policy_addr_o     (policy_addr_o),
        .policy_done_i     (policy_done_i),
        .policy_addr_i     (policy_addr_i),
        .mem_req_o         (mem_req_o),
        .mem_rw_o          (mem_rw_o),
        .mem_addr_o        (mem_addr_o),
        .mem_cache_addr_o  (mem_cache_addr_o),
        .mem_ack_i         (mem_ack_i)
    );

    int    checks = 0;
    int    errors = 0;
    string cur_lbl = "";

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s %s: got 0x%0h expected 0x%0h", cur_lbl, name, got, exp);
        end
    endtask

    // Reference model: each location remembers the whole block address it holds.
    bit m_valid [CAP];
    bit m_dirty [CAP];
    int m_addr  [CAP];

    typedef struct {
        bit hit;
        int loc;
        int set;
        int nmem;
        int wb_addr;
        int fill_addr;
    } exp_t;

    task automatic model_reset();
        for (int i = 0; i < CAP; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_addr[i]  = 0;
        end
    endtask

    task automatic model_access(input bit wr, input int addr, input int pv, output exp_t e);
        int set;
        int v;
        set = addr % SETS;
        v = -1;
        e.hit = 1'b0; e.loc = 0; e.set = set; e.nmem = 0; e.wb_addr = 0; e.fill_addr = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (!e.hit && m_valid[w*SETS+set] && m_addr[w*SETS+set] == addr) begin
                e.hit = 1'b1;
                e.loc = w*SETS + set;
            end
        end
        if (e.hit) begin
            if (wr) m_dirty[e.loc] = 1'b1;
        end else begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (!m_valid[w*SETS+set]) v = w*SETS + set;
            end
            if (v < 0) v = pv;
            e.loc = v;
            e.fill_addr = addr;
            e.nmem = 1;
            if (m_valid[v] && m_dirty[v]) begin
                e.nmem = 2;
                e.wb_addr = m_addr[v];
            end
            m_valid[v] = 1'b1;
            m_dirty[v] = wr;
            m_addr[v]  = addr;
        end
    endtask

    // Observations of one transaction.
    int o_phit, o_pmiss, o_paddr, o_resp, o_rhit, o_rloc, o_lat, o_nmem;
    int o_gap_bad, o_timeout, o_ready_bad, o_tail_bad, o_done_cyc, o_mfirst;
    int o_mrw [4];
    int o_maddr [4];
    int o_mcache [4];

    task automatic run_req(input bit wr, input int addr, input int pv, input int pw, input int mw);
        int cyc, cnt, waitc;
        bit pending, ack_prev, done_resp;
        o_phit = 0; o_pmiss = 0; o_paddr = -1; o_resp = 0; o_rhit = -1; o_rloc = -1; o_lat = -1;
        o_nmem = 0; o_gap_bad = 0; o_timeout = 0; o_ready_bad = 0; o_tail_bad = 0;
        o_done_cyc = 0; o_mfirst = -1;
        for (int i = 0; i < 4; i++) begin
            o_mrw[i] = -1; o_maddr[i] = -1; o_mcache[i] = -1;
        end
        waitc = 0;
        @(negedge clock_i);
        while (!req_ready_o && waitc < 50) begin
            @(negedge clock_i);
            waitc++;
        end
        if (!req_ready_o) begin
            o_timeout = 1;
            return;
        end
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = AW'(addr);
        @(posedge clock_i);
        cyc = 0; cnt = 0; pending = 1'b0; ack_prev = 1'b0; done_resp = 1'b0;
        while (!done_resp && cyc < 200) begin
            @(negedge clock_i);
            cyc++;
            req_valid_i   = 1'b0;
            policy_done_i = 1'b0;
            if (cyc == 1 && req_ready_o) o_ready_bad = 1;
            if (policy_hit_o) begin
                o_phit++;
                o_paddr = int'(policy_addr_o);
            end
            if (policy_miss_o) begin
                o_pmiss++;
                o_paddr = int'(policy_addr_o);
                o_done_cyc = cyc + pw;
            end
            if (o_done_cyc > 0 && cyc == o_done_cyc) begin
                policy_done_i = 1'b1;
                policy_addr_i = 3'(pv);
            end
            if (ack_prev) begin
                mem_ack_i = 1'b0;
                ack_prev = 1'b0;
                if (mem_req_o) o_gap_bad = 1;
            end else if (mem_req_o) begin
                if (!pending) begin
                    if (o_nmem == 0) o_mfirst = cyc;
                    if (o_nmem < 4) begin
                        o_mrw[o_nmem]    = int'(mem_rw_o);
                        o_maddr[o_nmem]  = int'(mem_addr_o);
                        o_mcache[o_nmem] = int'(mem_cache_addr_o);
                    end
                    o_nmem++;
                    pending = 1'b1;
                    cnt = mw;
                end
                if (cnt == 0) begin
                    mem_ack_i = 1'b1;
                    ack_prev = 1'b1;
                    pending = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (resp_valid_o) begin
                o_resp++;
                o_rhit = int'(resp_hit_o);
                o_rloc = int'(resp_cache_addr_o);
                o_lat  = cyc;
                policy_done_i = 1'b0;
                mem_ack_i = 1'b0;
                @(negedge clock_i);
                if (resp_valid_o || !req_ready_o) o_tail_bad = 1;
                done_resp = 1'b1;
            end
        end
        if (!done_resp) o_timeout = 1;
        policy_done_i = 1'b0;
        mem_ack_i = 1'b0;
        req_valid_i = 1'b0;
    endtask

    task automatic check_txn(input exp_t e);
        check("timeout", o_timeout, 0);
        check("resp_pulses", o_resp, 1);
        check("resp_hit", o_rhit, int'(e.hit));
        check("resp_loc", o_rloc, e.loc);
        check("pulse_tail", o_tail_bad, 0);
        check("ready_busy", o_ready_bad, 0);
        check("policy_hit_cnt", o_phit, e.hit ? 1 : 0);
        check("policy_miss_cnt", o_pmiss, e.hit ? 0 : 1);
        check("policy_addr", o_paddr, e.hit ? e.loc : e.set);
        check("mem_txn_cnt", o_nmem, e.nmem);
        check("mem_ack_gap", o_gap_bad, 0);
        if (e.hit) check("hit_latency", o_lat, 2);
        if (e.nmem == 2) begin
            check("wb_rw", o_mrw[0], 1);
            check("wb_addr", o_maddr[0], e.wb_addr);
            check("wb_loc", o_mcache[0], e.loc);
            check("fill_rw", o_mrw[1], 0);
            check("fill_addr", o_maddr[1], e.fill_addr);
            check("fill_loc", o_mcache[1], e.loc);
        end else if (e.nmem == 1) begin
            check("fill_rw", o_mrw[0], 0);
            check("fill_addr", o_maddr[0], e.fill_addr);
            check("fill_loc", o_mcache[0], e.loc);
        end
    endtask

    typedef struct {
        bit wr;
        int addr;
        int pv;
        int pw;
        int mw;
        bit hit;
        int loc;
        int nmem;
        int wb;
        int fill;
    } vec_t;

    vec_t tbl [10];

    initial begin
        exp_t e;
        exp_t dummy;
        bit   seen;

        //            wr    addr  pv   pw mw  hit  loc  nmem wb    fill
        tbl[0] = '{1'b0, 8'h05, 0,   1, 0, 1'b0, 1,   1,   0,    8'h05};
        tbl[1] = '{1'b0, 8'h05, 0,   1, 0, 1'b1, 1,   0,   0,    0};
        tbl[2] = '{1'b1, 8'h09, 1,   1, 1, 1'b0, 5,   1,   0,    8'h09};
        tbl[3] = '{1'b0, 8'h0D, 1,   2, 1, 1'b0, 1,   1,   0,    8'h0D};
        tbl[4] = '{1'b1, 8'h0D, 1,   1, 0, 1'b1, 1,   0,   0,    0};
        tbl[5] = '{1'b0, 8'h11, 1,   1, 2, 1'b0, 1,   2,   8'h0D, 8'h11};
        tbl[6] = '{1'b0, 8'h09, 1,   1, 0, 1'b1, 5,   0,   0,    0};
        tbl[7] = '{1'b0, 8'h22, 6,   1, 0, 1'b0, 2,   1,   0,    8'h22};
        tbl[8] = '{1'b1, 8'h15, 5,   2, 1, 1'b0, 5,   2,   8'h09, 8'h15};
        tbl[9] = '{1'b0, 8'h11, 1,   1, 0, 1'b1, 1,   0,   0,    0};

        model_reset();
        repeat (3) @(posedge clock_i);
        @(negedge clock_i);
        cur_lbl = "reset";
        check("req_ready", int'(req_ready_o), 1);
        check("resp_valid", int'(resp_valid_o), 0);
        check("resp_hit", int'(resp_hit_o), 0);
        check("resp_loc", int'(resp_cache_addr_o), 0);
        check("policy_hit", int'(policy_hit_o), 0);
        check("policy_miss", int'(policy_miss_o), 0);
        check("policy_addr", int'(policy_addr_o), 0);
        check("mem_req", int'(mem_req_o), 0);
        check("mem_rw", int'(mem_rw_o), 0);
        check("mem_addr", int'(mem_addr_o), 0);
        check("mem_loc", int'(mem_cache_addr_o), 0);
        reset_i = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cur_lbl = $sformatf("vec%0d", i);
            model_access(tbl[i].wr, tbl[i].addr, tbl[i].pv, dummy);
            run_req(tbl[i].wr, tbl[i].addr, tbl[i].pv, tbl[i].pw, tbl[i].mw);
            e.hit = tbl[i].hit; e.loc = tbl[i].loc; e.set = tbl[i].addr % SETS;
            e.nmem = tbl[i].nmem; e.wb_addr = tbl[i].wb; e.fill_addr = tbl[i].fill;
            check_txn(e);
        end

        // Set 1 is full: policy done arrives 6 cycles after the miss, so VICTIM waits 5 cycles first.
        cur_lbl = "policy_wait";
        model_access(1'b0, 8'h19, 5, e);
        run_req(1'b0, 8'h19, 5, 6, 0);
        check_txn(e);
        check("first_mem_cycle", o_mfirst, 8);

        // Reset while a fill is outstanding.
        cur_lbl = "reset_in_fill";
        @(negedge clock_i);
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = 8'h03;
        @(posedge clock_i);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock_i);
            req_valid_i = 1'b0;
            if (mem_req_o) seen = 1'b1;
        end
        check("fill_req_seen", int'(seen), 1);
        reset_i = 1'b1;
        @(negedge clock_i);
        reset_i = 1'b0;
        check("mem_req_after_rst", int'(mem_req_o), 0);
        check("ready_after_rst", int'(req_ready_o), 1);
        check("resp_after_rst", int'(resp_valid_o), 0);
        model_reset();
        cur_lbl = "after_reset_load";
        model_access(1'b0, 8'h05, 1, e);
        run_req(1'b0, 8'h05, 1, 1, 0);
        check_txn(e);

        for (int i = 0; i < 40; i++) begin
            int tag, set, way, addr, pw, mw;
            bit wr;
            tag  = $urandom_range(0, 5);
            set  = $urandom_range(0, 3);
            way  = $urandom_range(0, 1);
            wr   = 1'($urandom_range(0, 1));
            pw   = $urandom_range(1, 3);
            mw   = $urandom_range(0, 3);
            addr = tag * SETS + set;
            cur_lbl = $sformatf("rand%0d addr=0x%0h wr=%0d", i, addr, wr);
            model_access(wr, addr, way * SETS + set, e);
            run_req(wr, addr, way * SETS + set, pw, mw);
            check_txn(e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
